// File: rtl/dut_sobel_system_pkg.sv
// Shared constants and helpers for the Sobel edge-detection pipeline.
package dut_sobel_system_pkg;

    localparam int DEF_IMG_WIDTH = 720;
    localparam int DEF_IMG_HEIGHT = 540;
    localparam int DEF_RGB_DWIDTH = 24;
    localparam int DEF_GRAYSCALE_DWIDTH = 8;
    localparam int DEF_SOBEL_DWIDTH = 8;
    localparam int PIX_COUNT = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
    localparam int SOBEL_MAX = 255;

    // BGR word: [23:16]=B, [15:8]=G, [7:0]=R
    function automatic logic [7:0] rgb_to_gray(input logic [23:0] p);
        logic [9:0] sum;
        sum = 10'(p[7:0]) + 10'(p[15:8]) + 10'(p[23:16]);
        return 8'(sum / 10'd3);
    endfunction

endpackage

// File: rtl/dut_sobel_system_fifo.sv
// Show-ahead FIFO, depth 2**BUFFER; head reads 0 while empty.
module dut_sobel_system_fifo #(
    parameter int DWIDTH = 8,
    parameter int BUFFER = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DWIDTH-1:0] din,
    input  logic              wr_en,
    output logic              full,
    output logic [DWIDTH-1:0] dout,
    input  logic              rd_en,
    output logic              empty
);
    localparam int DEPTH = 2 ** BUFFER;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [BUFFER-1:0] wr_ptr;
    logic [BUFFER-1:0] rd_ptr;
    logic [BUFFER:0]   count;
    logic              wr_ok;
    logic              rd_ok;

    assign empty = (count == '0);
    assign full  = (count == (BUFFER + 1)'(DEPTH));
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dut_sobel_system_grayscale.sv
// Registered BGR-to-gray stage between the RGB and grayscale FIFOs.
module dut_sobel_system_grayscale
    import dut_sobel_system_pkg::*;
#(
    parameter int RGB_DWIDTH = DEF_RGB_DWIDTH,
    parameter int GRAYSCALE_DWIDTH = DEF_GRAYSCALE_DWIDTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [RGB_DWIDTH-1:0]       rgb_data,
    input  logic                        rgb_empty,
    output logic                        rgb_pop,
    output logic [GRAYSCALE_DWIDTH-1:0] gray_data,
    output logic                        gray_push,
    input  logic                        gray_full
);
    logic valid;
    logic advance;

    // The result register holds while the next FIFO is full
    assign advance   = !valid || !gray_full;
    assign rgb_pop   = advance && !rgb_empty;
    assign gray_push = valid && !gray_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid     <= 1'b0;
            gray_data <= '0;
        end else if (advance) begin
            valid <= !rgb_empty;
            if (!rgb_empty)
                gray_data <= GRAYSCALE_DWIDTH'(rgb_to_gray(24'(rgb_data)));
        end
    end

endmodule

// File: rtl/dut_sobel_system_sobel.sv
// 3x3 Sobel operator with shift window, in/out counters and frame drain.
module dut_sobel_system_sobel
    import dut_sobel_system_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int PIX = PIX_COUNT,
    parameter int GRAYSCALE_DWIDTH = DEF_GRAYSCALE_DWIDTH,
    parameter int SOBEL_DWIDTH = DEF_SOBEL_DWIDTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [GRAYSCALE_DWIDTH-1:0] gray_data,
    input  logic                        gray_empty,
    output logic                        gray_pop,
    output logic [SOBEL_DWIDTH-1:0]     sobel_data,
    output logic                        sobel_push,
    input  logic                        sobel_full
);
    localparam int W = IMG_WIDTH;
    localparam int TAPS = 2 * W + 3;
    localparam int CW = $clog2(PIX + W + 3);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(IMG_HEIGHT);

    logic [GRAYSCALE_DWIDTH-1:0] win [TAPS];
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic valid, advance, take, emit, last, border;
    logic signed [10:0] tl, tc, tr, ml, mr, bl, bc, br;
    logic signed [10:0] gx, gy;
    logic [10:0] ax, ay;
    logic [11:0] mag;
    logic [SOBEL_DWIDTH-1:0] pix;

    assign advance    = !valid || !sobel_full;
    assign sobel_push = valid && !sobel_full;
    // win[0] is the newest pixel; the centre sits W+1 taps back
    assign emit = advance && ((in_cnt == out_cnt + CW'(W + 2))
                  || (in_cnt == CW'(PIX)));
    assign take     = advance && !gray_empty && (in_cnt != CW'(PIX));
    assign gray_pop = take;
    assign last     = (out_cnt == CW'(PIX - 1));
    assign border   = (row == '0) || (row == YW'(IMG_HEIGHT - 1))
                   || (col == '0) || (col == XW'(W - 1));

    assign tl = 11'(win[2*W+2]);
    assign tc = 11'(win[2*W+1]);
    assign tr = 11'(win[2*W]);
    assign ml = 11'(win[W+2]);
    assign mr = 11'(win[W]);
    assign bl = 11'(win[2]);
    assign bc = 11'(win[1]);
    assign br = 11'(win[0]);

    assign gx  = tr + (mr <<< 1) + br - tl - (ml <<< 1) - bl;
    assign gy  = bl + (bc <<< 1) + br - tl - (tc <<< 1) - tr;
    assign ax  = gx[10] ? -gx : gx;
    assign ay  = gy[10] ? -gy : gy;
    assign mag = {1'b0, ax} + {1'b0, ay};
    assign pix = (mag[11:1] > 11'(SOBEL_MAX)) ? SOBEL_DWIDTH'(SOBEL_MAX)
                                              : SOBEL_DWIDTH'(mag[11:1]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < TAPS; j++) win[j] <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            col        <= '0;
            row        <= '0;
            valid      <= 1'b0;
            sobel_data <= '0;
        end else begin
            if (take) begin
                win[0] <= gray_data;
                for (int j = 1; j < TAPS; j++) win[j] <= win[j-1];
                in_cnt <= in_cnt + 1'b1;
            end
            if (advance) valid <= emit;
            if (emit) begin
                sobel_data <= border ? '0 : pix;
                if (last) begin
                    out_cnt <= '0;
                    in_cnt  <= '0;
                    col     <= '0;
                    row     <= '0;
                end else begin
                    out_cnt <= out_cnt + 1'b1;
                    if (col == XW'(W - 1)) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dut_sobel_system.sv
// Top level: RGB FIFO -> grayscale -> gray FIFO -> Sobel -> output FIFO.
module dut_sobel_system
    import dut_sobel_system_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int RGB_DWIDTH = DEF_RGB_DWIDTH,
    parameter int RGB_BUFFER = 2,
    parameter int GRAYSCALE_DWIDTH = DEF_GRAYSCALE_DWIDTH,
    parameter int GRAYSCALE_BUFFER = 2,
    parameter int SOBEL_DWIDTH = DEF_SOBEL_DWIDTH,
    parameter int SOBEL_BUFFER = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [RGB_DWIDTH-1:0]   fifo_rgb_din,
    output logic                    fifo_rgb_full,
    input  logic                    fifo_rgb_wr_en,
    output logic [SOBEL_DWIDTH-1:0] fifo_sobel_dout,
    output logic                    fifo_sobel_empty,
    input  logic                    fifo_sobel_rd_en
);
    logic [RGB_DWIDTH-1:0]       rgb_data;
    logic                        rgb_empty, rgb_pop;
    logic [GRAYSCALE_DWIDTH-1:0] gray_din, gray_dout;
    logic                        gray_push, gray_full;
    logic                        gray_empty, gray_pop;
    logic [SOBEL_DWIDTH-1:0]     sobel_din;
    logic                        sobel_push, sobel_full;

    dut_sobel_system_fifo #(.DWIDTH(RGB_DWIDTH), .BUFFER(RGB_BUFFER)) u_fifo_rgb (
        .clock(clock), .reset(reset),
        .din(fifo_rgb_din), .wr_en(fifo_rgb_wr_en), .full(fifo_rgb_full),
        .dout(rgb_data), .rd_en(rgb_pop), .empty(rgb_empty)
    );

    dut_sobel_system_grayscale #(
        .RGB_DWIDTH(RGB_DWIDTH), .GRAYSCALE_DWIDTH(GRAYSCALE_DWIDTH)
    ) u_gray (
        .clock(clock), .reset(reset),
        .rgb_data(rgb_data), .rgb_empty(rgb_empty), .rgb_pop(rgb_pop),
        .gray_data(gray_din), .gray_push(gray_push), .gray_full(gray_full)
    );

    dut_sobel_system_fifo #(
        .DWIDTH(GRAYSCALE_DWIDTH), .BUFFER(GRAYSCALE_BUFFER)
    ) u_fifo_gray (
        .clock(clock), .reset(reset),
        .din(gray_din), .wr_en(gray_push), .full(gray_full),
        .dout(gray_dout), .rd_en(gray_pop), .empty(gray_empty)
    );

    dut_sobel_system_sobel #(
        .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT),
        .PIX(IMG_WIDTH * IMG_HEIGHT),
        .GRAYSCALE_DWIDTH(GRAYSCALE_DWIDTH), .SOBEL_DWIDTH(SOBEL_DWIDTH)
    ) u_sobel (
        .clock(clock), .reset(reset),
        .gray_data(gray_dout), .gray_empty(gray_empty), .gray_pop(gray_pop),
        .sobel_data(sobel_din), .sobel_push(sobel_push),
        .sobel_full(sobel_full)
    );

    dut_sobel_system_fifo #(.DWIDTH(SOBEL_DWIDTH), .BUFFER(SOBEL_BUFFER)) u_fifo_sobel (
        .clock(clock), .reset(reset),
        .din(sobel_din), .wr_en(sobel_push), .full(sobel_full),
        .dout(fifo_sobel_dout), .rd_en(fifo_sobel_rd_en),
        .empty(fifo_sobel_empty)
    );

endmodule

// File: tb/tb_dut_sobel_system.sv
// Bench for dut_sobel_system on an 8x6 frame against a 2-D Sobel model.
module tb_dut_sobel_system;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] fifo_rgb_din = '0;
    logic        fifo_rgb_full;
    logic        fifo_rgb_wr_en = 1'b0;
    logic [7:0]  fifo_sobel_dout;
    logic        fifo_sobel_empty;
    logic        fifo_sobel_rd_en = 1'b0;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int popped = 0;
    bit hold_rd = 1'b0;
    logic [23:0] frame [N];
    logic [7:0]  exp_q [$];
    logic [7:0]  gtap [$];

    dut_sobel_system #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clock(clock), .reset(reset),
        .fifo_rgb_din(fifo_rgb_din), .fifo_rgb_full(fifo_rgb_full),
        .fifo_rgb_wr_en(fifo_rgb_wr_en),
        .fifo_sobel_dout(fifo_sobel_dout),
        .fifo_sobel_empty(fifo_sobel_empty),
        .fifo_sobel_rd_en(fifo_sobel_rd_en)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (dut.gray_push) gtap.push_back(dut.gray_din);

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gray_of(logic [23:0] p);
        return (int'(p[7:0]) + int'(p[15:8]) + int'(p[23:16])) / 3;
    endfunction

    function automatic int iabs(int v);
        return v < 0 ? -v : v;
    endfunction

    task automatic build_model();
        int g [N];
        int gx, gy, m;
        for (int i = 0; i < N; i++) g[i] = gray_of(frame[i]);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
                    exp_q.push_back(8'd0);
                end else begin
                    gx = g[(r-1)*W+c+1] + 2*g[r*W+c+1] + g[(r+1)*W+c+1]
                       - g[(r-1)*W+c-1] - 2*g[r*W+c-1] - g[(r+1)*W+c-1];
                    gy = g[(r+1)*W+c-1] + 2*g[(r+1)*W+c] + g[(r+1)*W+c+1]
                       - g[(r-1)*W+c-1] - 2*g[(r-1)*W+c] - g[(r-1)*W+c+1];
                    m = (iabs(gx) + iabs(gy)) / 2;
                    exp_q.push_back(8'(m > 255 ? 255 : m));
                end
            end
    endtask

    task automatic drive_frame(input int wr_pct);
        int i = 0;
        int cyc = 0;
        while (i < N && cyc < N * 60 + 500) begin
            @(posedge clock); #1;
            cyc++;
            fifo_rgb_wr_en = 1'b0;
            if (!fifo_rgb_full && $urandom_range(99) < wr_pct) begin
                fifo_rgb_din = frame[i];
                fifo_rgb_wr_en = 1'b1;
                i++;
                writes++;
            end
        end
        check("drive_count", i, N);
        @(posedge clock); #1;
        fifo_rgb_wr_en = 1'b0;
    endtask

    task automatic collect(input int rd_pct);
        int got = 0;
        int cyc = 0;
        while (got < N && cyc < N * 60 + 500) begin
            @(posedge clock); #1;
            cyc++;
            fifo_sobel_rd_en = 1'b0;
            if (!fifo_sobel_empty && !hold_rd && $urandom_range(99) < rd_pct) begin
                check($sformatf("pixel%0d", got), fifo_sobel_dout, exp_q.pop_front());
                fifo_sobel_rd_en = 1'b1;
                got++;
                popped++;
            end
        end
        check("output_count", got, N);
        @(posedge clock); #1;
        fifo_sobel_rd_en = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("empty_after_frame", fifo_sobel_empty, 1);
    endtask

    task automatic run_frame(input int wr_pct, input int rd_pct);
        exp_q.delete();
        build_model();
        fork
            drive_frame(wr_pct);
            collect(rd_pct);
        join
    endtask

    task automatic stall_monitor();
        int cyc = 0;
        int w0;
        while (popped < 3 && cyc < 2000) begin
            @(posedge clock); #1;
            cyc++;
        end
        hold_rd = 1'b1;
        w0 = writes;
        cyc = 0;
        while (!fifo_rgb_full && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("stall_full", fifo_rgb_full, 1);
        checks++;
        assert (writes - w0 <= 15) else begin
            errors++;
            $error("FAIL stall_writes: got %0d expected <= 15", writes - w0);
        end
        repeat (5) @(posedge clock);
        #1;
        check("stall_still_full", fifo_rgb_full, 1);
        hold_rd = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset_empty", fifo_sobel_empty, 1);
        check("reset_full", fifo_rgb_full, 0);
        check("reset_dout", fifo_sobel_dout, 0);
        reset = 1'b0;

        for (int i = 0; i < N; i++) frame[i] = 24'h5A3C1E;
        run_frame(100, 100);

        for (int i = 0; i < N; i++) frame[i] = (i % W >= 4) ? 24'hFFFFFF : 24'h000000;
        run_frame(100, 100);

        for (int i = 0; i < N; i++) frame[i] = 24'h000000;
        frame[2*W+3] = 24'h0000FF;
        gtap.delete();
        run_frame(100, 100);
        check("gray_tap_count", gtap.size(), N);
        check("gray_tap_red", gtap[2*W+3], 85);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) frame[i] = 24'($urandom);
            run_frame(50 + 20 * f, 70 - 20 * f);
        end

        for (int i = 0; i < N; i++) frame[i] = 24'($urandom);
        popped = 0;
        exp_q.delete();
        build_model();
        fork
            drive_frame(100);
            collect(100);
            stall_monitor();
        join

        begin
            int sent = 0;
            int cyc = 0;
            fifo_sobel_rd_en = 1'b1;
            while (sent < 1000 && cyc < 5000) begin
                @(posedge clock); #1;
                cyc++;
                fifo_rgb_wr_en = 1'b0;
                if (!fifo_rgb_full) begin
                    fifo_rgb_din = 24'($urandom);
                    fifo_rgb_wr_en = 1'b1;
                    sent++;
                end
            end
            check("abort_sent", sent, 1000);
            reset = 1'b1;
            fifo_rgb_wr_en = 1'b0;
            fifo_sobel_rd_en = 1'b0;
            @(posedge clock); #1;
            check("midreset_empty", fifo_sobel_empty, 1);
            check("midreset_full", fifo_rgb_full, 0);
            check("midreset_dout", fifo_sobel_dout, 0);
            reset = 1'b0;
            @(posedge clock); #1;
            check("postreset_empty", fifo_sobel_empty, 1);
        end

        for (int i = 0; i < N; i++) frame[i] = 24'($urandom);
        run_frame(80, 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
